// File: rtl/lfsr_job_arbiter_pkg.sv
// Shared types and constants for the LFSR job arbiter: FSM state encoding,
// operand width and the default watchdog limit.
package lfsr_job_arbiter_pkg;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_DEF = 511;

  typedef enum logic [2:0] {
    ST_DRAIN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } arb_state_e;

endpackage

// File: rtl/lfsr_job_arbiter_if.sv
// Requester and generator-core signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the requesters plus the core.
interface lfsr_job_arbiter_if
  import lfsr_job_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_sw;
  logic [N*DATA_W-1:0] req_seq;
  logic [N-1:0]        gnt;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [DATA_W-1:0]   rsp_num;
  logic                rsp_err;
  logic                arb_busy;
  logic                gen_start;
  logic [DATA_W-1:0]   gen_sw;
  logic [DATA_W-1:0]   gen_seq;
  logic                gen_busy;
  logic [DATA_W-1:0]   gen_num;

  modport slave (
    input  req, req_sw, req_seq, gen_busy, gen_num,
    output gnt, rsp_valid, rsp_id, rsp_num, rsp_err, arb_busy,
           gen_start, gen_sw, gen_seq
  );

  modport master (
    output req, req_sw, req_seq, gen_busy, gen_num,
    input  gnt, rsp_valid, rsp_id, rsp_num, rsp_err, arb_busy,
           gen_start, gen_sw, gen_seq
  );

endinterface

// File: rtl/lfsr_job_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping to the lowest index when none is found above it.
module lfsr_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // First pass covers [ptr, N-1], second pass the wrapped part [0, ptr-1].
    for (int k = 0; k < N; k++) begin
      if (!o_any && (k >= int'(i_ptr)) && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/lfsr_job_arbiter.sv
// Shares one LFSR generator core between N requesters: round-robin grant,
// operand latching, start/busy sequencing, tagged result return and watchdog.
module lfsr_job_arbiter
  import lfsr_job_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = 10
) (
  input logic               clk,
  input logic               rst,
  lfsr_job_arbiter_if.slave bus
);

  arb_state_e        r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_rsp_id;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_gnt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_gen_start;
  logic [DATA_W-1:0] r_rsp_num;
  logic [DATA_W-1:0] r_gen_sw;
  logic [DATA_W-1:0] r_gen_seq;

  logic [N-1:0]      w_pick_oh;
  logic [IDW-1:0]    w_pick_idx;
  logic              w_pick_any;
  logic [DATA_W-1:0] w_sw;
  logic [DATA_W-1:0] w_seq;
  logic              w_cnt_exp;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(TIMEOUT)) ? CW'(TIMEOUT) : c + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] k);
    return (k == IDW'(N - 1)) ? '0 : k + 1'b1;
  endfunction

  lfsr_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_comb begin
    w_sw  = '0;
    w_seq = '0;
    for (int k = 0; k < N; k++) begin
      if (w_pick_oh[k]) begin
        w_sw  = bus.req_sw[k*DATA_W +: DATA_W];
        w_seq = bus.req_seq[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_cnt_exp = (r_cnt == CW'(TIMEOUT));

  // Pulse outputs default low each cycle so every event is exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DRAIN;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_gen_start <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_num   <= '0;
      r_gen_sw    <= '0;
      r_gen_seq   <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_gen_start <= 1'b0;
      case (r_state)
        ST_DRAIN: begin
          if (!bus.gen_busy) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_pick_any && !bus.gen_busy) begin
            r_gnt     <= w_pick_oh;
            r_gen_sw  <= w_sw;
            r_gen_seq <= w_seq;
            r_rsp_id  <= w_pick_idx;
            r_ptr     <= ptr_next(w_pick_idx);
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_gen_start <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (bus.gen_busy) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_LO;
          end else if (w_cnt_exp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_num   <= '0;
            r_state     <= ST_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_WAIT_LO: begin
          if (!bus.gen_busy) begin
            r_rsp_valid <= 1'b1;
            r_rsp_num   <= bus.gen_num;
            r_state     <= ST_DONE;
          end else if (w_cnt_exp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_num   <= '0;
            r_state     <= ST_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_DRAIN;
        default: r_state <= ST_DRAIN;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_num   = r_rsp_num;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.arb_busy  = (r_state != ST_IDLE);
  assign bus.gen_start = r_gen_start;
  assign bus.gen_sw    = r_gen_sw;
  assign bus.gen_seq   = r_gen_seq;

endmodule

// File: tb/tb_lfsr_job_arbiter.sv
// Bench for lfsr_job_arbiter: behavioural generator core (with hang and
// stray-busy modes), golden LFSR function and round-robin reference model.
module tb_lfsr_job_arbiter;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 511;
  localparam int CW      = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_job_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  lfsr_job_arbiter #(
    .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  logic [7:0] sw_a [4];
  logic [7:0] seq_a[4];

  // Generator core: loads seed 8'h03 on start, busy rises 2 cycles after
  // start, then steps once per cycle until its step count equals seq_num.
  bit         hung  = 1'b0;
  bit         stray = 1'b0;
  logic       core_busy = 1'b0;
  logic [1:0] core_ph   = 2'd0;
  logic [7:0] core_num  = 8'h00;
  logic [7:0] core_cnt  = 8'h00;

  function automatic logic [7:0] core_step(input logic [7:0] x, input logic [7:0] sw);
    return {x[6:0], x[7] ^ (^(x[6:0] & sw[6:0]))};
  endfunction

  always @(posedge clk) begin
    if (!hung) begin
      if (core_ph == 2'd0 && bus.gen_start) begin
        core_ph  <= 2'd1;
        core_num <= 8'h03;
        core_cnt <= 8'h00;
      end else if (core_ph == 2'd1) begin
        core_busy <= 1'b1;
        core_ph   <= 2'd2;
      end else if (core_ph == 2'd2) begin
        if (core_cnt == bus.gen_seq) begin
          core_busy <= 1'b0;
          core_ph   <= 2'd0;
        end else begin
          core_num <= core_step(core_num, bus.gen_sw);
          core_cnt <= core_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.gen_busy = hung ? 1'b0 : (core_busy | stray);
  assign bus.gen_num  = core_num;

  // Golden result: seed 3 advanced seq times by the tap-mask feedback shift.
  function automatic logic [7:0] golden(input logic [7:0] sw, input logic [7:0] seq);
    logic [7:0] x;
    x = 8'h03;
    for (int i = 0; i < int'(seq); i++) x = {x[6:0], x[7] ^ (^(x[6:0] & sw[6:0]))};
    return x;
  endfunction

  function automatic int model_pick(input int ptr, input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ptr + i) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic apply_ops();
    for (int k = 0; k < N; k++) begin
      bus.req_sw[k*8 +: 8]  = sw_a[k];
      bus.req_seq[k*8 +: 8] = seq_a[k];
    end
  endtask

  task automatic wait_gnt(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (|bus.gnt) begin ok = 1'b1; n = i; break; end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; n = i; break; end
    end
  endtask

  task automatic do_reset();
    bit ok;
    bus.req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.arb_busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_drain arb_busy still %b, want 0", bus.arb_busy);
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    for (int k = 0; k < N; k++) begin sw_a[k] = 8'h00; seq_a[k] = 8'h00; end
    apply_ops();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.gen_start} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_pulses got %b want 0", {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.gen_start});
    end
    n_cmp++;
    if ({bus.rsp_id, bus.rsp_num, bus.gen_sw, bus.gen_seq} !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_data id=%h num=%h sw=%h seq=%h want 0", bus.rsp_id, bus.rsp_num, bus.gen_sw, bus.gen_seq);
    end
    n_cmp++;
    if (bus.arb_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_drain_busy got %b want 1", bus.arb_busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok; int n;
    do_reset();
    sw_a[0] = 8'h00; seq_a[0] = 8'h00;
    apply_ops();
    bus.req = 4'b0001;
    wait_gnt(ok, n);
    n_cmp++;
    if (!ok || bus.gnt !== 4'b0001) begin
      n_bad++; $display("FAIL single_gnt got %b want 0001", bus.gnt);
    end
    bus.req = '0;
    m_ptr = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.gen_start !== 1'b1 || bus.gnt !== 4'b0) begin
      n_bad++; $display("FAIL single_start gen_start=%b gnt=%b want 1/0000", bus.gen_start, bus.gnt);
    end
    wait_rsp(ok, n);
    n_cmp++;
    if (!ok || n != 4) begin
      n_bad++; $display("FAIL single_latency got %0d want 4", n);
    end
    n_cmp++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_num !== 8'h03 || bus.rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL single_rsp id=%0d num=%h err=%b want 0/03/0", bus.rsp_id, bus.rsp_num, bus.rsp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_num !== 8'h03) begin
      n_bad++; $display("FAIL single_pulse valid=%b num=%h want 0/03", bus.rsp_valid, bus.rsp_num);
    end
  endtask

  task automatic test_round_robin();
    bit ok; int n, exp;
    do_reset();
    for (int k = 0; k < N; k++) begin
      sw_a[k]  = 8'($urandom);
      seq_a[k] = 8'($urandom_range(40, 0));
    end
    apply_ops();
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp = model_pick(m_ptr, bus.req);
      wait_gnt(ok, n);
      n_cmp++;
      if (!ok || bus.gnt !== (4'b0001 << exp)) begin
        n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", j, bus.gnt, 4'b0001 << exp);
      end
      m_ptr = (exp + 1) % N;
      if (j == 4) bus.req = '0;
      wait_rsp(ok, n);
      n_cmp++;
      if (!ok || bus.rsp_id !== 2'(exp) || bus.rsp_num !== golden(sw_a[exp], seq_a[exp]) || bus.rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_rsp[%0d] id=%0d num=%h err=%b want %0d/%h/0", j, bus.rsp_id, bus.rsp_num, bus.rsp_err, exp, golden(sw_a[exp], seq_a[exp]));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok; int n, exp;
    do_reset();
    for (int k = 0; k < N; k++) begin
      sw_a[k]  = 8'($urandom);
      seq_a[k] = 8'($urandom_range(20, 0));
    end
    apply_ops();
    bus.req = 4'b0010;
    wait_gnt(ok, n);
    bus.req = '0;
    m_ptr = 2;
    wait_rsp(ok, n);
    bus.req = 4'b0011;
    for (int j = 0; j < 2; j++) begin
      exp = model_pick(m_ptr, bus.req);
      wait_gnt(ok, n);
      n_cmp++;
      if (!ok || bus.gnt !== (4'b0001 << exp)) begin
        n_bad++; $display("FAIL wrap_gnt[%0d] got %b want %b", j, bus.gnt, 4'b0001 << exp);
      end
      bus.req[exp] = 1'b0;
      m_ptr = (exp + 1) % N;
      wait_rsp(ok, n);
      n_cmp++;
      if (!ok || bus.rsp_id !== 2'(exp) || bus.rsp_num !== golden(sw_a[exp], seq_a[exp])) begin
        n_bad++; $display("FAIL wrap_rsp[%0d] id=%0d num=%h want %0d/%h", j, bus.rsp_id, bus.rsp_num, exp, golden(sw_a[exp], seq_a[exp]));
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; int n;
    do_reset();
    hung = 1'b1;
    sw_a[2] = 8'h5a; seq_a[2] = 8'h07;
    apply_ops();
    bus.req = 4'b0100;
    wait_gnt(ok, n);
    bus.req = '0;
    @(negedge clk);
    wait_rsp(ok, n);
    n_cmp++;
    if (!ok || n != TIMEOUT + 1) begin
      n_bad++; $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_num !== 8'h00 || bus.rsp_id !== 2'd2) begin
      n_bad++; $display("FAIL timeout_rsp err=%b num=%h id=%0d want 1/00/2", bus.rsp_err, bus.rsp_num, bus.rsp_id);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.arb_busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_idle arb_busy=%b valid=%b want 0/0", bus.arb_busy, bus.rsp_valid);
    end
    hung = 1'b0;
  endtask

  task automatic test_reset_midjob();
    bit ok; int n, bad_ev;
    do_reset();
    sw_a[3] = 8'($urandom); seq_a[3] = 8'd200;
    apply_ops();
    bus.req = 4'b1000;
    wait_gnt(ok, n);
    bus.req = '0;
    for (int i = 0; i < 100 && !bus.gen_busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    n_cmp++;
    if (bus.gnt !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.arb_busy !== 1'b1 || bus.gen_sw !== 8'h00) begin
      n_bad++; $display("FAIL midrst_state gnt=%b valid=%b busy=%b sw=%h want 0000/0/1/00", bus.gnt, bus.rsp_valid, bus.arb_busy, bus.gen_sw);
    end
    sw_a[0] = 8'($urandom); seq_a[0] = 8'($urandom_range(30, 1));
    apply_ops();
    bus.req = 4'b0001;
    bad_ev = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.gen_busy) break;
      if (|bus.gnt || bus.rsp_valid) bad_ev++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_ev != 0 || bus.gen_busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_drain events=%0d busy=%b want 0/0", bad_ev, bus.gen_busy);
    end
    wait_gnt(ok, n);
    n_cmp++;
    if (!ok || bus.gnt !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_gnt got %b want 0001", bus.gnt);
    end
    bus.req = '0;
    m_ptr = 1;
    wait_rsp(ok, n);
    n_cmp++;
    if (!ok || bus.rsp_num !== golden(sw_a[0], seq_a[0]) || bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd0) begin
      n_bad++; $display("FAIL midrst_rsp num=%h err=%b id=%0d want %h/0/0", bus.rsp_num, bus.rsp_err, bus.rsp_id, golden(sw_a[0], seq_a[0]));
    end
  endtask

  task automatic test_operand_latch();
    bit ok; int n;
    logic [7:0] sw_l, seq_l;
    do_reset();
    sw_a[1] = 8'($urandom); seq_a[1] = 8'd60;
    sw_l = sw_a[1]; seq_l = seq_a[1];
    apply_ops();
    bus.req = 4'b0010;
    wait_gnt(ok, n);
    bus.req = '0;
    sw_a[1] = ~sw_l; seq_a[1] = 8'd5;
    apply_ops();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (bus.gen_sw !== sw_l || bus.gen_seq !== seq_l) begin
      n_bad++; $display("FAIL latch_ops sw=%h seq=%h want %h/%h", bus.gen_sw, bus.gen_seq, sw_l, seq_l);
    end
    wait_rsp(ok, n);
    n_cmp++;
    if (!ok || bus.rsp_num !== golden(sw_l, seq_l) || bus.rsp_id !== 2'd1) begin
      n_bad++; $display("FAIL latch_rsp num=%h id=%0d want %h/1", bus.rsp_num, bus.rsp_id, golden(sw_l, seq_l));
    end
  endtask

  task automatic test_stray_busy();
    bit ok; int n, gcount;
    do_reset();
    sw_a[0] = 8'($urandom); seq_a[0] = 8'($urandom_range(15, 0));
    apply_ops();
    stray = 1'b1;
    bus.req = 4'b0001;
    gcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (|bus.gnt) gcount++;
    end
    n_cmp++;
    if (gcount != 0) begin
      n_bad++; $display("FAIL stray_nognt got %0d grants want 0", gcount);
    end
    stray = 1'b0;
    wait_gnt(ok, n);
    n_cmp++;
    if (!ok || bus.gnt !== 4'b0001) begin
      n_bad++; $display("FAIL stray_gnt got %b want 0001", bus.gnt);
    end
    bus.req = '0;
    wait_rsp(ok, n);
    n_cmp++;
    if (!ok || bus.rsp_num !== golden(sw_a[0], seq_a[0])) begin
      n_bad++; $display("FAIL stray_rsp num=%h want %h", bus.rsp_num, golden(sw_a[0], seq_a[0]));
    end
  endtask

  initial begin
    bus.req     = '0;
    bus.req_sw  = '0;
    bus.req_seq = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_midjob();
    test_operand_latch();
    test_stray_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
